// File: rtl/ctrl_seq_fsm.sv
// Multicycle control sequencer: accepts an instruction, steps IDLE->T1->T2->T3, and decodes datapath strobes.
// Optional build macro CTRL_SEQ_STALL_EN adds a stall input that freezes T1..T3 and masks the strobes.
module ctrl_seq_fsm #(
    parameter  int RSEL_W  = 3,
    parameter  int DATA_W  = 10,
    localparam int NREG    = 2**RSEL_W,
    localparam int INSTR_W = 4 + 2*RSEL_W
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CTRL_SEQ_STALL_EN
    input  logic               stall,
`endif
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [NREG-1:0]    rin,
    output logic [NREG-1:0]    rout,
    output logic               ext,
    output logic               imm_en,
    output logic [DATA_W-1:0]  imm_out,
    output logic               ain,
    output logic               gin,
    output logic               gout,
    output logic [2:0]         alu_op,
    output logic               irin,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_T1   = 2'd1;
    localparam logic [1:0] S_T2   = 2'd2;
    localparam logic [1:0] S_T3   = 2'd3;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOVE = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b1000;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [3:0]         opc;
    logic [RSEL_W-1:0]  fx;
    logic [RSEL_W-1:0]  fy;
    logic               hold;

    assign opc = ir[INSTR_W-1 -: 4];
    assign fx  = ir[2*RSEL_W-1 -: RSEL_W];
    assign fy  = ir[RSEL_W-1:0];

`ifdef CTRL_SEQ_STALL_EN
    assign hold = stall && (state != S_IDLE);
`else
    assign hold = 1'b0;
`endif

    function automatic logic [NREG-1:0] onehot(input logic [RSEL_W-1:0] sel);
        return NREG'(1) << sel;
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_SUB:  return 3'b001;
            OP_INV:  return 3'b010;
            OP_AND:  return 3'b011;
            OP_OR:   return 3'b100;
            OP_XOR:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] imm_zext(input logic [RSEL_W-1:0] v);
        return DATA_W'(v);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    always_comb begin
        state_nxt   = state;
        rin         = '0;
        rout        = '0;
        ext         = 1'b0;
        imm_en      = 1'b0;
        ain         = 1'b0;
        gin         = 1'b0;
        gout        = 1'b0;
        alu_op      = 3'b000;
        done        = 1'b0;
        err         = 1'b0;
        instr_ready = (state == S_IDLE);
        irin        = (state == S_IDLE) && instr_valid;
        busy        = (state != S_IDLE);
        imm_out     = imm_zext(fy);

        case (state)
            S_IDLE: begin
                if (instr_valid) state_nxt = S_T1;
            end
            S_T1: begin
                if (opc == OP_LOAD) begin
                    ext       = 1'b1;
                    rin       = onehot(fx);
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (opc == OP_MOVE) begin
                    rout      = onehot(fy);
                    rin       = onehot(fx);
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (is_alu(opc)) begin
                    rout      = onehot(fx);
                    ain       = 1'b1;
                    state_nxt = S_T2;
                end else begin
                    err       = 1'b1;
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_T2: begin
                gin       = 1'b1;
                alu_op    = alu_code(opc);
                state_nxt = S_T3;
                if (opc == OP_ADDI) begin
                    imm_en = 1'b1;
                end else if (opc != OP_INV) begin
                    rout = onehot(fy);
                end
            end
            S_T3: begin
                gout      = 1'b1;
                rin       = onehot(fx);
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Stall freezes the step and masks every strobe; alu_op and imm_out stay decoded.
        if (hold) begin
            state_nxt = state;
            rin       = '0;
            rout      = '0;
            ext       = 1'b0;
            imm_en    = 1'b0;
            ain       = 1'b0;
            gin       = 1'b0;
            gout      = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
        end

        if (reset) begin
            state_nxt   = S_IDLE;
            rin         = '0;
            rout        = '0;
            ext         = 1'b0;
            imm_en      = 1'b0;
            ain         = 1'b0;
            gin         = 1'b0;
            gout        = 1'b0;
            alu_op      = 3'b000;
            done        = 1'b0;
            err         = 1'b0;
            instr_ready = 1'b0;
            irin        = 1'b0;
            busy        = 1'b0;
            imm_out     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (irin) ir <= instr;
        end
    end

endmodule

// File: tb/tb_ctrl_seq_fsm.sv
// Directed bench for ctrl_seq_fsm: a per-cycle vector table plus hand-written latency, reset-abort and stall sequences.
module tb_ctrl_seq_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ext;
    logic       imm_en;
    logic [9:0] imm_out;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [2:0] alu_op;
    logic       irin;
    logic       busy;
    logic       done;
    logic       err;
`ifdef CTRL_SEQ_STALL_EN
    logic       stall = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_seq_fsm dut (
        .clk(clk),
        .reset(reset),
`ifdef CTRL_SEQ_STALL_EN
        .stall(stall),
`endif
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .rin(rin),
        .rout(rout),
        .ext(ext),
        .imm_en(imm_en),
        .imm_out(imm_out),
        .ain(ain),
        .gin(gin),
        .gout(gout),
        .alu_op(alu_op),
        .irin(irin),
        .busy(busy),
        .done(done),
        .err(err)
    );

    logic [38:0] act;
    assign act = {instr_ready, irin, rin, rout, ext, imm_en, imm_out, ain, gin, gout, alu_op, busy, done, err};

    typedef struct {
        logic        rst;
        logic        vld;
        logic [9:0]  ins;
        logic [38:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Field order: ready irin rin rout ext imm_en imm ain gin gout alu busy done err
    function automatic logic [38:0] ex(input int rdy, input int ir, input int ri, input int ro,
                                       input int ex_, input int ie, input int imm, input int a,
                                       input int g, input int go, input int alu, input int b,
                                       input int d, input int e);
        return {1'(rdy), 1'(ir), 8'(ri), 8'(ro), 1'(ex_), 1'(ie), 10'(imm), 1'(a), 1'(g), 1'(go),
                3'(alu), 1'(b), 1'(d), 1'(e)};
    endfunction

    task automatic row(input int r, input int v, input int i, input logic [38:0] e);
        vec_t t;
        t.rst = 1'(r);
        t.vld = 1'(v);
        t.ins = 10'(i);
        t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [38:0] a, input logic [38:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, a, e);
        end
    endtask

    task automatic issue(input logic [9:0] i);
        @(negedge clk);
        instr       = i;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Called at the first negedge after accept; reports the cycle index of done (0 on timeout).
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) $display("FAIL %s timeout waiting for done", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);

        row(1, 1, 'h018, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 1, 'h018, ex(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,'h08,0,1,0,0,0,0,0,0,1,1,0));
        row(0, 0, 'h000, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 1, 'h04D, ex(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,'h02,'h20,0,0,5,0,0,0,0,1,1,0));
        row(0, 1, 'h0D6, ex(1,1,0,0,0,0,5,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h04,0,0,6,1,0,0,0,1,0,0));
        row(0, 1, 'h038, ex(0,0,0,'h40,0,0,6,0,1,0,1,1,0,0));
        row(0, 0, 'h000, ex(0,0,'h04,0,0,0,6,0,0,1,0,1,1,0));
        row(0, 1, 'h23D, ex(1,1,0,0,0,0,6,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h80,0,0,5,1,0,0,0,1,0,0));
        row(0, 0, 'h000, ex(0,0,0,0,0,1,5,0,1,0,0,1,0,0));
        row(0, 0, 'h000, ex(0,0,'h80,0,0,0,5,0,0,1,0,1,1,0));
        row(0, 1, 'h3C0, ex(1,1,0,0,0,0,5,0,0,0,0,0,0,0));
        row(0, 1, 'h081, ex(0,0,0,0,0,0,0,0,0,0,0,1,1,1));
        row(0, 1, 'h081, ex(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h01,0,0,1,1,0,0,0,1,0,0));
        row(1, 0, 'h000, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 1, 'h1DC, ex(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h08,0,0,4,1,0,0,0,1,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h10,0,0,4,0,1,0,5,1,0,0));
        row(0, 0, 'h000, ex(0,0,'h08,0,0,0,4,0,0,1,0,1,1,0));
        row(0, 1, 'h128, ex(1,1,0,0,0,0,4,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h20,0,0,0,1,0,0,0,1,0,0));
        row(0, 0, 'h000, ex(0,0,0,0,0,0,0,0,1,0,2,1,0,0));
        row(0, 0, 'h000, ex(0,0,'h20,0,0,0,0,0,0,1,0,1,1,0));
        row(0, 1, 'h052, ex(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,'h04,'h04,0,0,2,0,0,0,0,1,1,0));
        row(0, 1, 'h170, ex(1,1,0,0,0,0,2,0,0,0,0,0,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h40,0,0,0,1,0,0,0,1,0,0));
        row(0, 0, 'h000, ex(0,0,0,'h01,0,0,0,0,1,0,3,1,0,0));
        row(0, 0, 'h000, ex(0,0,'h40,0,0,0,0,0,0,1,0,1,1,0));

        foreach (tbl[n]) begin
            @(negedge clk);
            reset       = tbl[n].rst;
            instr_valid = tbl[n].vld;
            instr       = tbl[n].ins;
            #1;
            chk($sformatf("vec%0d", n), act, tbl[n].exp);
        end

        // ALU latency: done three cycles after the accept edge
        issue(10'h0D6);
        wait_done("sub_latency", lat);
        chk_int("sub_latency", lat, 3);
        chk("sub_t3", act, ex(0,0,'h04,0,0,0,6,0,0,1,0,1,1,0));

        // Reset during T3 aborts without a done pulse
        issue(10'h081);
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 10'h018;
        #1;
        chk("rst_t3", act, '0);
        @(negedge clk);
        #1;
        chk("rst_hold", act, '0);
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("rst_release", act, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

        issue(10'h018);
        wait_done("load_latency", lat);
        chk_int("load_latency", lat, 1);
        chk("load_t1", act, ex(0,0,'h08,0,1,0,0,0,0,0,0,1,1,0));

`ifdef CTRL_SEQ_STALL_EN
        issue(10'h0D6);
        stall = 1'b1;
        #1;
        chk("stall_t1", act, ex(0,0,0,0,0,0,6,0,0,0,0,1,0,0));
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("stall_t1_resume", act, ex(0,0,0,'h04,0,0,6,1,0,0,0,1,0,0));
        @(negedge clk);
        stall = 1'b1;
        #1;
        chk("stall_t2", act, ex(0,0,0,0,0,0,6,0,0,0,1,1,0,0));
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("stall_t2_resume", act, ex(0,0,0,'h40,0,0,6,0,1,0,1,1,0,0));
        @(negedge clk);
        #1;
        chk("stall_t3", act, ex(0,0,'h04,0,0,0,6,0,0,1,0,1,1,0));
        @(negedge clk);
        stall       = 1'b1;
        instr_valid = 1'b1;
        instr       = 10'h018;
        #1;
        chk("stall_idle_accept", act, ex(1,1,0,0,0,0,6,0,0,0,0,0,0,0));
        @(negedge clk);
        stall       = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("stall_idle_load", act, ex(0,0,'h08,0,1,0,0,0,0,0,0,1,1,0));
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
